// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external single-cycle ALU between two requesters.
// Accept in IDLE, drive the ALU for one EXEC cycle, hold the result in RESP until taken.
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*WIDTH-1:0]  req_srcA,
  input  logic [2*WIDTH-1:0]  req_srcB,
  input  logic [2*CTRL_W-1:0] req_ctrl,
  output logic [1:0]          resp_valid,
  input  logic [1:0]          resp_ready,
  output logic [WIDTH-1:0]    resp_data,
  output logic [WIDTH-1:0]    alu_srcA,
  output logic [WIDTH-1:0]    alu_srcB,
  output logic [CTRL_W-1:0]   alu_ctrl,
  input  logic [WIDTH-1:0]    alu_result,
  output logic                busy,
  output logic                grant_id
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                grant_q, grant_d;
  logic [WIDTH-1:0]    srca_q, srca_d;
  logic [WIDTH-1:0]    srcb_q, srcb_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [WIDTH-1:0]    result_q, result_d;

  logic                sel;
  logic                sel_vld;
  logic [WIDTH-1:0]    sel_srca;
  logic [WIDTH-1:0]    sel_srcb;
  logic [CTRL_W-1:0]   sel_ctrl;

  // On a tie the requester that did not win last time gets the ALU.
  always_comb begin
    sel_vld = |req_valid;
    case (req_valid)
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~last_grant_q;
      default: sel = 1'b0;
    endcase
    sel_srca = sel ? req_srcA[2*WIDTH-1:WIDTH]   : req_srcA[WIDTH-1:0];
    sel_srcb = sel ? req_srcB[2*WIDTH-1:WIDTH]   : req_srcB[WIDTH-1:0];
    sel_ctrl = sel ? req_ctrl[2*CTRL_W-1:CTRL_W] : req_ctrl[CTRL_W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    srca_d       = srca_q;
    srcb_d       = srcb_q;
    ctrl_d       = ctrl_q;
    result_d     = result_q;
    req_ready    = 2'b00;
    resp_valid   = 2'b00;
    resp_data    = '0;
    alu_srcA     = '0;
    alu_srcB     = '0;
    alu_ctrl     = '0;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          req_ready[sel] = 1'b1;
          srca_d         = sel_srca;
          srcb_d         = sel_srcb;
          ctrl_d         = sel_ctrl;
          grant_d        = sel;
          last_grant_d   = sel;
          state_d        = EXEC;
        end
      end
      EXEC: begin
        alu_srcA = srca_q;
        alu_srcB = srcb_q;
        alu_ctrl = ctrl_q;
        result_d = alu_result;
        state_d  = RESP;
      end
      RESP: begin
        alu_srcA            = srca_q;
        alu_srcB            = srcb_q;
        alu_ctrl            = ctrl_q;
        resp_valid[grant_q] = 1'b1;
        resp_data           = result_q;
        if (resp_ready[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      srca_q       <= '0;
      srcb_q       <= '0;
      ctrl_q       <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      srca_q       <= srca_d;
      srcb_q       <= srcb_d;
      ctrl_q       <= ctrl_d;
      result_q     <= result_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign grant_id = grant_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to its ALU ports.
module tb_alu_arbiter;
  localparam int WIDTH  = 32;
  localparam int CTRL_W = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*WIDTH-1:0]  req_srcA;
  logic [2*WIDTH-1:0]  req_srcB;
  logic [2*CTRL_W-1:0] req_ctrl;
  logic [1:0]          resp_valid;
  logic [1:0]          resp_ready;
  logic [WIDTH-1:0]    resp_data;
  logic [WIDTH-1:0]    alu_srcA;
  logic [WIDTH-1:0]    alu_srcB;
  logic [CTRL_W-1:0]   alu_ctrl;
  logic [WIDTH-1:0]    alu_result;
  logic                busy;
  logic                grant_id;

  int n_assert = 0;
  int n_fail   = 0;

  alu_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_srcA(req_srcA), .req_srcB(req_srcB), .req_ctrl(req_ctrl),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // External ALU: AND, OR, ADD, SUB, unsigned less-than; anything else yields 0.
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_srcA & alu_srcB;
      4'b0001: alu_result = alu_srcA | alu_srcB;
      4'b0010: alu_result = alu_srcA + alu_srcB;
      4'b0110: alu_result = alu_srcA - alu_srcB;
      4'b0111: alu_result = {31'd0, (alu_srcA < alu_srcB)};
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".resp_valid"}, resp_valid, 0);
    chk({tag, ".resp_data"}, resp_data, 0);
    chk({tag, ".alu_srcA"}, alu_srcA, 0);
    chk({tag, ".alu_srcB"}, alu_srcB, 0);
    chk({tag, ".alu_ctrl"}, alu_ctrl, 0);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 2'b00;
    req_srcA   = '0;
    req_srcB   = '0;
    req_ctrl   = '0;
    resp_ready = 2'b00;
    step();
    step();
    chk_idle_outputs("rst");
    chk("rst.req_ready", req_ready, 0);
    chk("rst.grant_id", grant_id, 0);
    reset = 1'b0;

    // Single ADD on port 0 with response taken immediately
    req_srcA   = {32'd0, 32'd5};
    req_srcB   = {32'd0, 32'd7};
    req_ctrl   = {4'd0, 4'b0010};
    resp_ready = 2'b11;
    req_valid  = 2'b01;
    #1;
    chk("add.T.req_ready", req_ready, 2'b01);
    chk("add.T.busy", busy, 0);
    step();
    req_valid = 2'b00;
    #1;
    chk("add.T1.busy", busy, 1);
    chk("add.T1.req_ready", req_ready, 0);
    chk("add.T1.alu_srcA", alu_srcA, 5);
    chk("add.T1.alu_srcB", alu_srcB, 7);
    chk("add.T1.alu_ctrl", alu_ctrl, 4'b0010);
    chk("add.T1.resp_valid", resp_valid, 0);
    step();
    chk("add.T2.resp_valid", resp_valid, 2'b01);
    chk("add.T2.resp_data", resp_data, 12);
    chk("add.T2.busy", busy, 1);
    chk("add.T2.alu_srcA_hold", alu_srcA, 5);
    step();
    chk_idle_outputs("add.T3");
    req_valid = 2'b01;
    #1;
    chk("add.T3.req_ready", req_ready, 2'b01);
    req_valid = 2'b00;

    // Both ports valid from reset, held for six ops: strict alternation
    reset = 1'b1;
    step();
    reset      = 1'b0;
    req_srcA   = {32'h0000_0000, 32'hF0F0_F0F0};
    req_srcB   = {32'h0000_0001, 32'hFF00_FF00};
    req_ctrl   = {4'b0110, 4'b0000};
    resp_ready = 2'b11;
    req_valid  = 2'b11;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rr%0d.req_ready", k), req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      step();
      chk($sformatf("rr%0d.grant_id", k), grant_id, k % 2);
      chk($sformatf("rr%0d.exec_ready", k), req_ready, 0);
      step();
      chk($sformatf("rr%0d.resp_valid", k), resp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("rr%0d.resp_data", k), resp_data,
          (k % 2 == 0) ? 32'hF000_F000 : 32'hFFFF_FFFF);
      chk($sformatf("rr%0d.resp_ready_out", k), req_ready, 0);
      step();
    end

    // Port 1 unsigned less-than, response stalled with only the wrong ready bit high
    req_srcA   = {32'hFFFF_FFFF, 32'd1};
    req_srcB   = {32'd1, 32'd2};
    req_ctrl   = {4'b0111, 4'b0001};
    resp_ready = 2'b01;
    req_valid  = 2'b10;
    #1;
    chk("slt.req_ready", req_ready, 2'b10);
    step();
    req_valid = 2'b01;
    #1;
    chk("slt.exec_grant", grant_id, 1);
    chk("slt.exec_ready", req_ready, 0);
    step();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("slt.stall%0d.resp_valid", c), resp_valid, 2'b10);
      chk($sformatf("slt.stall%0d.resp_data", c), resp_data, 0);
      chk($sformatf("slt.stall%0d.req_ready", c), req_ready, 0);
      step();
    end
    resp_ready = 2'b11;
    #1;
    chk("slt.release.resp_valid", resp_valid, 2'b10);
    step();
    chk("slt.after.busy", busy, 0);
    chk("slt.after.resp_valid", resp_valid, 0);
    chk("slt.after.req_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    #1;
    chk("or0.grant_id", grant_id, 0);
    step();
    chk("or0.resp_data", resp_data, 3);
    chk("or0.resp_valid", resp_valid, 2'b01);
    step();

    // Reset during EXEC of 3|4 aborts the op
    req_srcA  = {32'd0, 32'd3};
    req_srcB  = {32'd0, 32'd4};
    req_ctrl  = {4'd0, 4'b0001};
    req_valid = 2'b01;
    #1;
    chk("abort.req_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    #1;
    chk("abort.exec_ctrl", alu_ctrl, 4'b0001);
    chk("abort.exec_srcA", alu_srcA, 3);
    reset = 1'b1;
    step();
    chk_idle_outputs("abort.rst");
    chk("abort.rst.grant_id", grant_id, 0);
    chk("abort.rst.req_ready", req_ready, 0);
    reset = 1'b0;
    step();
    chk("abort.after.resp_valid", resp_valid, 0);
    chk("abort.after.busy", busy, 0);

    // Undefined ctrl on port 1; resp_ready[0] must not complete it
    req_srcA   = {32'd9, 32'd0};
    req_srcB   = {32'd9, 32'd0};
    req_ctrl   = {4'b1111, 4'd0};
    resp_ready = 2'b01;
    req_valid  = 2'b10;
    #1;
    chk("undef.req_ready", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    #1;
    chk("undef.grant_id", grant_id, 1);
    chk("undef.alu_ctrl", alu_ctrl, 4'b1111);
    step();
    chk("undef.resp_valid", resp_valid, 2'b10);
    chk("undef.resp_data", resp_data, 0);
    step();
    chk("undef.wrongbit.resp_valid", resp_valid, 2'b10);
    chk("undef.wrongbit.busy", busy, 1);
    resp_ready = 2'b10;
    step();
    chk("undef.done.busy", busy, 0);
    chk("undef.done.resp_valid", resp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single-cycle integer ALU between two requesters, for example the execute stage and an address-generation or debug unit. Each requester issues an op with a valid/ready handshake. The arbiter grants one requester round-robin, registers the operands and drives them into the ALU. It captures the ALU result and returns it to the granted requester with a valid/ready response handshake. The ALU itself stays outside this block; only its ports are driven and sampled here.

Parameters:
WIDTH, 32, operand/result width
CTRL_W, 4, ALU_control width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  2  bit i: requester i has an op pending
req_ready  output  2  bit i: op of requester i accepted this cycle
req_srcA  input  2*WIDTH  requester i operand A at bits [i*WIDTH +: WIDTH]
req_srcB  input  2*WIDTH  requester i operand B, same packing
req_ctrl  input  2*CTRL_W  requester i ALU_control code, same packing
resp_valid  output  2  bit i: result for requester i available
resp_ready  input  2  bit i: requester i takes the result
resp_data  output  WIDTH  result (shared, qualified by resp_valid)
alu_srcA  output  WIDTH  to ALU srcA
alu_srcB  output  WIDTH  to ALU srcB
alu_ctrl  output  CTRL_W  to ALU ALU_control
alu_result  input  WIDTH  from ALU ALU_result (combinational)
busy  output  1  high when state is not IDLE
grant_id  output  1  requester currently owning the ALU

Behaviour:
- States: IDLE, EXEC, RESP. All state is registered.
- Reset (sync): state=IDLE, last_grant=1 (so port 0 wins the first tie), operand/ctrl/result regs=0, grant_id=0.
- Reset outputs: req_ready=0, resp_valid=0, resp_data=0, alu_srcA/B=0, alu_ctrl=0, busy=0.
- Reset mid-operation aborts the op. No response is issued.
- IDLE grant selection:
  - Only one bit of req_valid set: that requester is selected.
  - Both set: the requester != last_grant is selected.
  - None set: no selection.
- IDLE accept:
  - req_ready[sel]=1 combinationally in IDLE when req_valid[sel]=1. The other bit is 0.
  - At the handshake edge, capture the selected srcA/srcB/ctrl, set grant_id=sel and last_grant=sel, then go to EXEC.
- req_ready is 0 in EXEC and RESP. At most one req_ready bit is ever high.
- EXEC (exactly 1 cycle):
  - alu_srcA/alu_srcB/alu_ctrl = captured registers.
  - At the edge, result_reg <= alu_result, then go to RESP.
- ALU port values outside EXEC:
  - Hold the captured values in RESP.
  - Drive 0 in IDLE. ctrl 0 is AND, so 0&0 gives a harmless 0.
- ctrl codes pass through unmodified. Undefined codes are not filtered; the ALU returns 0 for them.
- RESP:
  - resp_valid[grant_id]=1 and resp_data=result_reg. Both are stable until the handshake.
  - resp_valid[grant_id] && resp_ready[grant_id] at an edge: go to IDLE and clear resp_valid.
  - resp_ready on the non-granted bit is ignored.
- Latency:
  - Accept edge at cycle T; resp_valid high from cycle T+2.
  - Minimum of 3 cycles per op when resp_ready is held high.
  - New accept no earlier than the cycle after the response handshake; no bypass from RESP to accept.
- Fairness:
  - With both requesters continuously valid, grants alternate 0,1,0,1.
  - A requester waits at most one other op.
- Arithmetic is the ALU's own:
  - Wrap-around mod 2^WIDTH.
  - Unsigned less-than.
  - The arbiter adds no width extension.
- req_valid dropping before its handshake is permitted; no op is taken.
- resp_data is 0 outside RESP.

Test Plan:
- Port 0 requests ADD (0010), A=5, B=7, resp_ready=1 -> req_ready[0] at T, resp_valid[0] at T+2 with resp_data=12, busy high for T+1..T+2, next accept possible at T+3.
- Both ports valid from reset: port 0 AND (0000) 0xF0F0F0F0,0xFF00FF00 and port 1 SUB (0110) 0,1 -> port 0 served first with result 0xF000F000, then port 1 with result 0xFFFFFFFF; grant_id 0 then 1.
- Both held valid for 6 ops -> grant order 0,1,0,1,0,1; req_ready never high for both bits at once.
- Port 1 LESS_THAN (0111) A=0xFFFFFFFF, B=1 with resp_ready[1]=0 for 5 cycles -> resp_valid[1] and resp_data=0 held stable, port 0 valid not accepted; release resp_ready -> IDLE next cycle, port 0 then accepted.
- reset asserted during EXEC of OR (0001) 3|4 -> next cycle all outputs 0 and state IDLE, no resp_valid; a fresh request afterwards completes normally.
- Undefined ctrl 1111 with A=9, B=9 -> response issued normally with resp_data=0; wrong-bit resp_ready[0] during a port 1 response does not complete it.
